// File: rtl/ddc_pkg.sv
// Shared constants for the DDC back end: CIC decimator widths and the
// power-of-two rescale that restores unity DC gain.
package ddc_pkg;
  localparam int unsigned IN_WIDTH  = 18;
  localparam int unsigned OUT_WIDTH = 18;
  localparam int unsigned STAGES    = 4;
  localparam int unsigned MAX_LOG2  = 6;
  localparam int unsigned ACC_WIDTH = IN_WIDTH + STAGES * MAX_LOG2;
  localparam int unsigned K_WIDTH   = 3;
  localparam int unsigned SH_WIDTH  = $clog2(ACC_WIDTH);

  // CIC gain is R^N = 2^(N*k); the width difference is folded into the same shift.
  function automatic logic [SH_WIDTH-1:0] cic_shift(input logic [K_WIDTH-1:0] k);
    return SH_WIDTH'(STAGES * k + IN_WIDTH - OUT_WIDTH);
  endfunction
endpackage

// File: rtl/cic_channel.sv
// One rail of the CIC decimator: pipelined integrators, launch register,
// comb chain with per-stage x_prev, and round-half-up rescale.
module cic_channel
  import ddc_pkg::*;
(
  input  logic                        clk,
  input  logic                        i_flush,
  input  logic                        i_accept,
  input  logic                        i_adv,
  input  logic [STAGES+1:0]           i_vld,
  input  logic [SH_WIDTH-1:0]         i_shift,
  input  logic signed [IN_WIDTH-1:0]  i_din,
  output logic signed [OUT_WIDTH-1:0] o_dout
);
  logic signed [ACC_WIDTH-1:0] r_integ [STAGES];
  logic signed [ACC_WIDTH-1:0] r_comb  [STAGES];
  logic signed [ACC_WIDTH-1:0] r_xprev [STAGES];
  logic signed [ACC_WIDTH-1:0] r_launch;
  logic signed [OUT_WIDTH-1:0] r_dout;
  logic signed [ACC_WIDTH-1:0] w_x [STAGES];
  logic signed [ACC_WIDTH-1:0] w_bias;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [OUT_WIDTH-1:0] w_round;

  always_comb begin
    w_x[0] = r_launch;
    for (int unsigned s = 1; s < STAGES; s++) w_x[s] = r_comb[s-1];
  end

  assign w_bias  = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (i_shift - 1'b1);
  assign w_sum   = r_comb[STAGES-1] + w_bias;
  assign w_round = OUT_WIDTH'(w_sum >>> i_shift);

  always_ff @(posedge clk) begin
    if (i_flush) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_integ[s] <= '0;
        r_comb[s]  <= '0;
        r_xprev[s] <= '0;
      end
      r_launch <= '0;
      r_dout   <= '0;
    end else begin
      // Integrators wrap modulo 2^ACC_WIDTH; the combs cancel the wrap exactly.
      if (i_accept) begin
        r_integ[0] <= r_integ[0] + {{(ACC_WIDTH-IN_WIDTH){i_din[IN_WIDTH-1]}}, i_din};
        for (int unsigned s = 1; s < STAGES; s++) r_integ[s] <= r_integ[s] + r_integ[s-1];
      end
      if (i_adv) begin
        if (i_vld[0]) r_launch <= r_integ[STAGES-1];
        for (int unsigned s = 0; s < STAGES; s++) begin
          if (i_vld[s+1]) begin
            r_comb[s]  <= w_x[s] - r_xprev[s];
            r_xprev[s] <= w_x[s];
          end
        end
        if (i_vld[STAGES+1]) r_dout <= w_round;
      end
    end
  end

  assign o_dout = r_dout;
endmodule

// File: rtl/cic_decimator.sv
// Dual-rail (I/Q) CIC decimator, R = 2^k chosen at runtime, unity DC gain,
// valid/ready output; shared phase/valid/stall control drives both rails.
module cic_decimator
  import ddc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           decim_log2,
  input  logic                 cfg_load,
  input  logic [IN_WIDTH-1:0]  in_i,
  input  logic [IN_WIDTH-1:0]  in_q,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_i,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 cfg_err,
  output logic [15:0]          sample_cnt
);
  logic [K_WIDTH-1:0]  r_k;
  logic [MAX_LOG2-1:0] r_phase;
  logic [STAGES+1:0]   r_vld;
  logic                r_out_valid;
  logic                r_cfg_err;
  logic [15:0]         r_cnt;
  logic                w_flush;
  logic                w_stall;
  logic                w_accept;
  logic                w_last;
  logic                w_k_ok;
  logic [MAX_LOG2-1:0] w_rmax;
  logic [SH_WIDTH-1:0] w_shift;

  assign w_flush  = rst | cfg_load;
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~cfg_load & ~rst;
  assign w_accept = in_valid & in_ready;
  assign w_rmax   = ~({MAX_LOG2{1'b1}} << r_k);
  assign w_last   = (r_phase == w_rmax);
  assign w_k_ok   = (decim_log2 != '0) && (decim_log2 <= K_WIDTH'(MAX_LOG2));
  assign w_shift  = cic_shift(r_k);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_phase     <= '0;
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      if (rst) begin
        r_k       <= K_WIDTH'(1);
        r_cfg_err <= 1'b0;
      end else if (w_k_ok) begin
        r_k <= decim_log2;
      end else begin
        r_k       <= K_WIDTH'(1);
        r_cfg_err <= 1'b1;
      end
    end else begin
      if (w_accept) r_phase <= w_last ? '0 : r_phase + 1'b1;
      // Not stalled means the output register is empty or being drained this cycle.
      if (!w_stall) begin
        r_vld <= {r_vld[STAGES:0], w_accept & w_last};
        if (r_vld[STAGES+1]) begin
          r_out_valid <= 1'b1;
          r_cnt       <= r_cnt + 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  cic_channel u_chan_i (
    .clk      (clk),
    .i_flush  (w_flush),
    .i_accept (w_accept),
    .i_adv    (~w_stall),
    .i_vld    (r_vld),
    .i_shift  (w_shift),
    .i_din    (in_i),
    .o_dout   (out_i)
  );

  cic_channel u_chan_q (
    .clk      (clk),
    .i_flush  (w_flush),
    .i_accept (w_accept),
    .i_adv    (~w_stall),
    .i_vld    (r_vld),
    .i_shift  (w_shift),
    .i_din    (in_q),
    .o_dout   (out_q)
  );

  assign out_valid  = r_out_valid;
  assign cfg_err    = r_cfg_err;
  assign sample_cnt = r_cnt;
endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: randomized and directed I/Q streams checked against a
// decimated-FIR reference built from the CIC transfer function.
module tb_cic_decimator;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  decim_log2;
  logic        cfg_load;
  logic [17:0] in_i;
  logic [17:0] in_q;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_i;
  logic [17:0] out_q;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_err;
  logic [15:0] sample_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int kcur = 1;
  int xi[$];
  int xq[$];
  logic [17:0] gi[$];
  logic [17:0] gq[$];
  int acc_edge[$];
  int out_edge[$];

  always #5 clk = ~clk;

  cic_decimator dut (
    .clk        (clk),
    .rst        (rst),
    .decim_log2 (decim_log2),
    .cfg_load   (cfg_load),
    .in_i       (in_i),
    .in_q       (in_q),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_err    (cfg_err),
    .sample_cnt (sample_cnt)
  );

  // Reference: 4-stage CIC == FIR with h = coeffs of ((1-z^-R)/(1-z^-1))^4,
  // the pipelined integrator chain adds 3 samples of pure delay, output m is
  // taken at accepted sample m*R+R-1, then rounded right shift by 4k.
  function automatic logic [17:0] model_out(input int k, input int m, input bit rail_q);
    int r;
    int n;
    int s;
    longint h[];
    longint t[];
    longint y;
    r = 1 << k;
    h = new[1];
    h[0] = 1;
    for (int st = 0; st < 4; st++) begin
      t = new[h.size() + r - 1];
      foreach (t[a]) t[a] = 0;
      for (int a = 0; a < h.size(); a++)
        for (int b = 0; b < r; b++) t[a+b] += h[a];
      h = t;
    end
    n = m * r + r - 1 - 3;
    y = 0;
    for (int j = 0; j < h.size(); j++) begin
      if (n - j >= 0 && n - j < xi.size())
        y += h[j] * longint'(rail_q ? xq[n-j] : xi[n-j]);
    end
    s = 4 * k;
    y = (y + (longint'(1) << (s - 1))) >>> s;
    return y[17:0];
  endfunction

  task automatic drive(input bit v, input int i, input int q);
    in_valid = v;
    in_i = 18'(i);
    in_q = 18'(q);
  endtask

  // One clock: log the handshakes the coming edge performs, then advance to the next negedge.
  task automatic cycle();
    bit fl;
    #1;
    fl = rst || cfg_load;
    if (in_valid && in_ready) begin
      xi.push_back(int'($signed(in_i)));
      xq.push_back(int'($signed(in_q)));
      acc_edge.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      gi.push_back(out_i);
      gq.push_back(out_q);
      out_edge.push_back(cyc);
    end
    @(posedge clk);
    if (fl) begin
      xi.delete(); xq.delete(); gi.delete(); gq.delete();
      acc_edge.delete(); out_edge.delete();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    kcur = 1;
  endtask

  task automatic do_cfg(input int k);
    decim_log2 = 3'(k);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
    kcur = (k >= 1 && k <= 6) ? k : 1;
  endtask

  task automatic test_reset();
    drive(1, 5, -5);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    cycle();
    rst = 1'b0;
    kcur = 1;
    vectors++;
    if ({out_valid, cfg_err} !== 2'b00 || out_i !== 18'd0 || out_q !== 18'd0 || sample_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b e=%b i=%0d q=%0d cnt=%0d exp all 0", out_valid, cfg_err, out_i, out_q, sample_cnt);
    end
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_dc_gain();
    do_rst();
    do_cfg(3);
    out_ready = 1'b1;
    drive(1, 1000, -1000);
    repeat (106) cycle();
    drive(0, 0, 0);
    repeat (12) cycle();
    vectors++;
    if (gi.size() != xi.size() / 8) begin miscompares++; $display("FAIL dc_count got=%0d exp=%0d", gi.size(), xi.size() / 8); end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL dc_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
      if (m >= 4) begin
        vectors++;
        if (gi[m] !== 18'd1000 || gq[m] !== -18'sd1000) begin
          miscompares++;
          $display("FAIL dc_steady[%0d] got=%0d/%0d exp=1000/-1000", m, $signed(gi[m]), $signed(gq[m]));
        end
      end
      if (m >= 1) begin
        vectors++;
        if (out_edge[m] - out_edge[m-1] != 8) begin
          miscompares++;
          $display("FAIL dc_spacing[%0d] got=%0d exp=8", m, out_edge[m] - out_edge[m-1]);
        end
      end
    end
    if (gi.size() > 0 && acc_edge.size() > 7) begin
      vectors++;
      if (out_edge[0] - 1 - acc_edge[7] != 6) begin
        miscompares++;
        $display("FAIL dc_latency got=%0d exp=6", out_edge[0] - 1 - acc_edge[7]);
      end
    end
  endtask

  task automatic test_impulse_latency();
    int si, sq;
    do_cfg(1);
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive(1, (c == 10) ? 4096 : 0, (c == 10) ? -4096 : 0);
      cycle();
    end
    drive(0, 0, 0);
    repeat (12) cycle();
    si = 0;
    sq = 0;
    vectors++;
    if (gi.size() != 20) begin miscompares++; $display("FAIL imp_count got=%0d exp=20", gi.size()); end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      si += int'($signed(gi[m]));
      sq += int'($signed(gq[m]));
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL imp_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
    end
    vectors++;
    if (si != 2048 || sq != -2048) begin miscompares++; $display("FAIL imp_area got=%0d/%0d exp=2048/-2048", si, sq); end
    if (gi.size() > 0 && acc_edge.size() > 1) begin
      vectors++;
      if (out_edge[0] - 1 - acc_edge[1] != 6) begin
        miscompares++;
        $display("FAIL imp_latency got=%0d exp=6", out_edge[0] - 1 - acc_edge[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_cfg(2);
    for (int c = 0; c < 200; c++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom), int'($urandom));
      out_ready = (c >= 60 && c < 80) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        miscompares++;
        $display("FAIL bp_in_ready[%0d] got=%b exp=%b", c, in_ready, !(out_valid && !out_ready));
      end
      cycle();
    end
    drive(0, 0, 0);
    out_ready = 1'b1;
    repeat (20) cycle();
    vectors++;
    if (gi.size() != xi.size() / 4) begin miscompares++; $display("FAIL bp_count got=%0d exp=%0d", gi.size(), xi.size() / 4); end
    vectors++;
    if (sample_cnt !== 16'(xi.size() / 4)) begin
      miscompares++;
      $display("FAIL bp_sample_cnt got=%0d exp=%0d", sample_cnt, xi.size() / 4);
    end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL bp_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
    end
  endtask

  task automatic test_full_scale();
    do_cfg(6);
    out_ready = 1'b1;
    drive(1, -131072, 131071);
    repeat (2000) cycle();
    drive(0, 0, 0);
    repeat (20) cycle();
    vectors++;
    if (gi.size() != 2000 / 64) begin miscompares++; $display("FAIL fs_count got=%0d exp=%0d", gi.size(), 2000 / 64); end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL fs_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
      if (m >= 4) begin
        vectors++;
        if (gi[m] !== 18'h20000 || gq[m] !== 18'h1FFFF) begin
          miscompares++;
          $display("FAIL fs_steady[%0d] got=%0d/%0d exp=-131072/131071", m, $signed(gi[m]), $signed(gq[m]));
        end
      end
    end
  endtask

  task automatic test_reconfig();
    do_cfg(2);
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      drive(1, int'($urandom), int'($urandom));
      cycle();
    end
    decim_log2 = 3'd7;
    cfg_load = 1'b1;
    drive(1, 100000, -100000);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rc_in_ready got=%b exp=0", in_ready); end
    cycle();
    cfg_load = 1'b0;
    kcur = 1;
    vectors++;
    if (cfg_err !== 1'b1 || out_valid !== 1'b0 || sample_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rc_state got err=%b v=%b cnt=%0d exp 1/0/0", cfg_err, out_valid, sample_cnt);
    end
    for (int c = 0; c < 40; c++) begin
      drive($urandom_range(0, 1) != 0, int'($urandom), int'($urandom));
      cycle();
    end
    drive(0, 0, 0);
    repeat (10) cycle();
    vectors++;
    if (gi.size() != xi.size() / 2) begin miscompares++; $display("FAIL rc_count got=%0d exp=%0d", gi.size(), xi.size() / 2); end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL rc_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
    end
    do_cfg(2);
    vectors++;
    if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL rc_sticky got=%b exp=1", cfg_err); end
    for (int c = 0; c < 40; c++) begin
      drive(1, int'($urandom), int'($urandom));
      cycle();
    end
    drive(0, 0, 0);
    repeat (10) cycle();
    vectors++;
    if (gi.size() != xi.size() / 4) begin miscompares++; $display("FAIL rc2_count got=%0d exp=%0d", gi.size(), xi.size() / 4); end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL rc2_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    int budget;
    do_cfg(1);
    out_ready = 1'b0;
    budget = 0;
    while (out_valid !== 1'b1 && budget < 40) begin
      drive(1, int'($urandom), int'($urandom));
      cycle();
      budget++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rs_wait_valid timeout got=%b exp=1", out_valid); end
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rs_stall_in_ready got=%b exp=0", in_ready); end
    do_rst();
    vectors++;
    if ({out_valid, cfg_err} !== 2'b00 || out_i !== 18'd0 || out_q !== 18'd0 || sample_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rs_state got v=%b e=%b i=%0d q=%0d cnt=%0d exp all 0", out_valid, cfg_err, out_i, out_q, sample_cnt);
    end
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rs_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      drive(1, int'($urandom), int'($urandom));
      cycle();
    end
    drive(0, 0, 0);
    repeat (10) cycle();
    vectors++;
    if (gi.size() != xi.size() / 2) begin miscompares++; $display("FAIL rs_count got=%0d exp=%0d", gi.size(), xi.size() / 2); end
    for (int m = 0; m < gi.size(); m++) begin
      logic [17:0] ei, eq;
      ei = model_out(kcur, m, 0);
      eq = model_out(kcur, m, 1);
      vectors++;
      if (gi[m] !== ei || gq[m] !== eq) begin
        miscompares++;
        $display("FAIL rs_model[%0d] got=%0d/%0d exp=%0d/%0d", m, $signed(gi[m]), $signed(gq[m]), $signed(ei), $signed(eq));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_load = 1'b0;
    decim_log2 = 3'd1;
    in_valid = 1'b0;
    in_i = '0;
    in_q = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_dc_gain();
    test_impulse_latency();
    test_backpressure();
    test_full_scale();
    test_reconfig();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
